// File: rtl/ones_run_sched.sv
// Shared consecutive-ones run counter: NCH serial bit sources time-share one
// saturating increment/clear datapath under round-robin arbitration.
module ones_run_sched #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         bit_in,
    input  logic [NCH-1:0]         clr,
    output logic [NCH-1:0]         ack,
    output logic                   out_vld,
    output logic [$clog2(NCH)-1:0] out_ch,
    output logic [CW-1:0]          out_cnt,
    output logic                   out_sat
);

    localparam int CHW = $clog2(NCH);
    localparam logic [CW-1:0] MAX = '1;

    logic [CW-1:0]  cnt [NCH];
    logic [CHW-1:0] rr_ptr;

    logic [NCH-1:0] elig;
    logic           grant_vld;
    logic [CHW-1:0] grant_idx;
    int unsigned    scan_idx;
    logic [CW-1:0]  cur_cnt;
    logic [CW-1:0]  next_cnt;

    // A channel acked this cycle still holds its old request, so it is masked.
    assign elig = req & ~clr & ~ack;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        scan_idx  = 0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NCH;
            if (!grant_vld && elig[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = CHW'(scan_idx);
            end
        end
    end

    always_comb begin
        cur_cnt  = cnt[grant_idx];
        next_cnt = '0;
        if (bit_in[grant_idx]) begin
            next_cnt = (cur_cnt == MAX) ? MAX : cur_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
            ack     <= '0;
            out_vld <= 1'b0;
            out_ch  <= '0;
            out_cnt <= '0;
            out_sat <= 1'b0;
            rr_ptr  <= CHW'(NCH - 1);
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (clr[i]) begin
                    cnt[i] <= '0;
                end else if (grant_vld && (grant_idx == CHW'(i))) begin
                    cnt[i] <= next_cnt;
                end
            end
            ack     <= grant_vld ? (NCH'(1) << grant_idx) : '0;
            out_vld <= grant_vld;
            if (grant_vld) begin
                out_ch  <= grant_idx;
                out_cnt <= next_cnt;
                out_sat <= (next_cnt == MAX);
                rr_ptr  <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_ones_run_sched.sv
// Directed bench for ones_run_sched (NCH=4, CW=2) with hand-computed expectations.
module tb_ones_run_sched;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] req = '0;
    logic [NCH-1:0] bit_in = '0;
    logic [NCH-1:0] clr = '0;
    logic [NCH-1:0] ack;
    logic           out_vld;
    logic [1:0]     out_ch;
    logic [CW-1:0]  out_cnt;
    logic           out_sat;

    int checks = 0;
    int failures = 0;

    ones_run_sched #(.NCH(NCH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .bit_in(bit_in), .clr(clr),
        .ack(ack), .out_vld(out_vld), .out_ch(out_ch), .out_cnt(out_cnt),
        .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_upd(input string tag, input int ch, input int cnt, input logic sat);
        check({tag, ".ack"}, 32'(ack), 32'(1 << ch));
        check({tag, ".vld"}, 32'(out_vld), 1);
        check({tag, ".ch"}, 32'(out_ch), 32'(ch));
        check({tag, ".cnt"}, 32'(out_cnt), 32'(cnt));
        check({tag, ".sat"}, 32'(out_sat), 32'(sat));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".ack"}, 32'(ack), 0);
        check({tag, ".vld"}, 32'(out_vld), 0);
    endtask

    task automatic expect_zero_outputs(input string tag);
        expect_idle(tag);
        check({tag, ".ch"}, 32'(out_ch), 0);
        check({tag, ".cnt"}, 32'(out_cnt), 0);
        check({tag, ".sat"}, 32'(out_sat), 0);
    endtask

    initial begin
        int   exp1 [5];
        logic sat1 [5];
        logic bits1 [5];
        exp1  = '{1, 2, 3, 3, 0};
        sat1  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        bits1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset values
        #2;
        expect_zero_outputs("rst");
        #6 rst_n = 1'b1;

        // Single channel run: 1,1,1,1,0 -> 1,2,3,3,0, acks two cycles apart
        req = 4'b0001;
        bit_in[0] = bits1[0];
        for (int j = 0; j < 5; j++) begin
            tick();
            expect_upd($sformatf("run%0d", j), 0, exp1[j], sat1[j]);
            if (j < 4) bit_in[0] = bits1[j + 1];
            else req = '0;
            tick();
            expect_idle($sformatf("gap%0d", j));
            check($sformatf("gap%0d.hold", j), 32'(out_cnt), 32'(exp1[j]));
        end

        // Fresh reset, all four channels streaming ones
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        req = 4'b1111;
        bit_in = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            tick();
            expect_upd($sformatf("rr%0d", k), k % 4, k / 4 + 1, (k / 4 + 1) == 3);
            if (k == 11) req = '0;
        end

        // rr_ptr -> 1, then req 0101: channel 2 wins before channel 0
        req = 4'b0010;
        bit_in = 4'b0010;
        tick();
        expect_upd("p1", 1, 3, 1'b1);
        req = 4'b0101;
        bit_in = 4'b0001;
        tick();
        expect_upd("p2", 2, 0, 1'b0);
        req = 4'b0001;
        tick();
        expect_upd("p0", 0, 3, 1'b1);
        req = '0;
        tick();
        expect_idle("p_idle");

        // Clear beats a same-cycle request
        req = 4'b0100;
        bit_in = 4'b0100;
        tick();
        expect_upd("c1", 2, 1, 1'b0);
        tick();
        expect_idle("c_gap");
        tick();
        expect_upd("c2", 2, 2, 1'b0);
        req = '0;
        tick();
        expect_idle("c_idle");
        clr = 4'b0100;
        req = 4'b0100;
        tick();
        expect_idle("c_clr");
        clr = '0;
        tick();
        expect_upd("c3", 2, 1, 1'b0);
        req = '0;

        // Outputs hold while idle after ch3 reaches 2
        clr = 4'b1000;
        tick();
        expect_idle("h_clr");
        clr = '0;
        req = 4'b1000;
        bit_in = 4'b1000;
        tick();
        expect_upd("h1", 3, 1, 1'b0);
        tick();
        expect_idle("h_gap");
        tick();
        expect_upd("h2", 3, 2, 1'b0);
        req = '0;
        for (int j = 0; j < 3; j++) begin
            tick();
            expect_idle($sformatf("hold%0d", j));
            check($sformatf("hold%0d.ch", j), 32'(out_ch), 3);
            check($sformatf("hold%0d.cnt", j), 32'(out_cnt), 2);
            check($sformatf("hold%0d.sat", j), 32'(out_sat), 0);
        end

        // Asynchronous reset mid-stream
        req = 4'b1111;
        bit_in = 4'b1111;
        tick();
        expect_upd("a0", 0, 3, 1'b1);
        tick();
        expect_upd("a1", 1, 3, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        expect_zero_outputs("arst");
        #4 rst_n = 1'b1;
        tick();
        expect_upd("a_post0", 0, 1, 1'b0);
        tick();
        expect_upd("a_post1", 1, 1, 1'b0);
        req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ones_run_sched.md
# ones_run_sched

Shared run-length scheduler: up to NCH serial bit sources share one consecutive-ones counting engine. Per-channel run counts sit in an internal register file. One shared saturating increment/clear datapath services one channel per cycle under round-robin arbitration. Each granted update is acknowledged, and the updated count is reported the following cycle. It sits between the per-lane bit producers and the downstream run-threshold logic. It replaces per-lane copies of the consecutive-ones FSM.

## Interface
- NCH, default 4: number of requesting channels (2..16).
- CW, default 2: run-count width; count saturates at MAX = 2^CW-1 (3 by default).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NCH  per-channel update request; held high with bit_in stable until ack.
- bit_in  input  NCH  per-channel data bit qualified by req.
- clr  input  NCH  per-channel synchronous clear of stored count.
- ack  output  NCH  registered one-hot; bit i high for one cycle = channel i's bit consumed.
- out_vld  output  1  registered; high for one cycle with each ack.
- out_ch  output  $clog2(NCH)  channel index of the reported update.
- out_cnt  output  CW  updated run count of out_ch.
- out_sat  output  1  out_cnt == MAX.

## Operation
- Storage: cnt[i] (CW bits) per channel and rr_ptr (last granted index).
- Eligibility in cycle t: req[i] & ~clr[i] & ~ack[i]. A channel whose ack is high this cycle is masked, so it cannot be regranted on the same, still-held request.
- Arbitration: combinational round-robin. Search starts at rr_ptr+1 (mod NCH) and ascends with wrap. The first eligible channel g wins.
- Update of winner g at edge:
  - bit_in[g]=1: cnt[g] = min(cnt[g]+1, MAX). Saturating; never wraps to 0.
  - bit_in[g]=0: cnt[g] = 0.
- Same edge: ack[g]=1, out_vld=1, out_ch=g, out_cnt=new cnt[g], out_sat=(new cnt[g]==MAX), rr_ptr=g.
- No eligible channel: ack=0, out_vld=0. out_ch, out_cnt, out_sat and rr_ptr hold their values.
- clr[i]=1: cnt[i]=0 at the edge, for any number of channels simultaneously. Clear beats update because a clearing channel is ineligible. Clear produces no ack or out_vld.
- Non-granted channels keep cnt unchanged.
- Requester protocol: sample ack at an edge. If still requesting, present the next bit in the cycle ack is seen. That bit is eligible from the following cycle. Maximum rate is one update per channel per 2 cycles. Aggregate throughput is 1 update/cycle when ≥2 channels request.

## Timing
- Reset (rst_n low, asynchronous, any time): all cnt=0, ack=0, out_vld=0, out_ch=0, out_cnt=0, out_sat=0, rr_ptr=NCH-1, so channel 0 has first priority.
- Reset mid-operation discards in-flight grants. No ack is issued for requests pending at reset.
- First edge after rst_n rises may grant.
- Latency: request eligible in cycle t → ack/out_* valid in cycle t+1 (1 edge).
- Starvation bound: an eligible, uncleared channel is granted within NCH cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset, then req[0]=1 with bits 1,1,1,1,0 presented per ack: out_cnt = 1,2,3,3,0; out_sat = 0,0,1,1,0; ack[0] spaced exactly 2 cycles apart.
- req=4'b1111 held with bit_in=4'b1111 from reset: grant order 0,1,2,3,0,…; out_vld high every cycle; each channel reaches out_cnt=3 on its 3rd grant.
- rr_ptr=1 with req=4'b0101: channel 2 is granted before 0; then channel 0 on the next cycle.
- cnt[2]=2, then clr[2]=1 and req[2]=1 in the same cycle: no ack[2] that cycle; next cycle's grant with bit 1 reports out_cnt=1.
- Assert rst_n low for half a cycle mid-stream with pending reqs: all outputs go 0 immediately without a clock edge; after release, channel 0 is granted first and counts restart from 0.
- Idle with req=0 after an update to ch 3 cnt 2: out_vld=0; out_ch=3 and out_cnt=2 hold.
